// File: rtl/serial_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and a 1-entry output buffer.
// Optional break detection (break_o) is built when SERIAL_RX_BREAK_DET_EN is defined.
`timescale 1ns/1ps

module serial_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
`ifdef SERIAL_RX_BREAK_DET_EN
  output logic       busy_o,
  output logic       break_o
`else
  output logic       busy_o
`endif
);

  localparam int DIV   = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] tick_cnt;
  logic [3:0]       sub_cnt;
  logic [2:0]       bit_cnt;
  logic [3:0]       idle_cnt;
  logic [7:0]       shift;
  logic             samp_a;
  logic             samp_b;
  logic             tick;
  logic             vote_now;
  logic             vote;

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end
  end

  assign tick     = (tick_cnt == TICK_LAST);
  assign vote_now = tick && (sub_cnt == 4'd9);
  // Majority of the samples taken at sub-ticks 7 and 8 plus the live value at sub-tick 9.
  assign vote     = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      sub_cnt     <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      shift       <= '0;
      samp_a      <= 1'b0;
      samp_b      <= 1'b0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
`ifdef SERIAL_RX_BREAK_DET_EN
      break_o     <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses <= so every branch below sees pre-edge values,
      // and a later assignment in the block overrides these pulse/handshake defaults.
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (valid_o && ready_i) valid_o <= 1'b0;

      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      if (tick) begin
        sub_cnt <= sub_cnt + 4'd1;
        if (sub_cnt == 4'd7) samp_a <= rx_sync;
        if (sub_cnt == 4'd8) samp_b <= rx_sync;
      end

      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state    <= START;
            busy_o   <= 1'b1;
            tick_cnt <= '0;
            sub_cnt  <= '0;
          end
        end

        START: begin
          if (vote_now) begin
            if (!vote) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end

        DATA: begin
          if (vote_now) begin
            shift   <= {vote, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end

        STOP: begin
          if (vote_now) begin
            if (vote) begin
              // Holding register: reload when empty or drained this very cycle.
              if (!valid_o || ready_i) begin
                data_o  <= shift;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              frame_err_o <= 1'b1;
              idle_cnt    <= '0;
              state       <= WAIT_IDLE;
`ifdef SERIAL_RX_BREAK_DET_EN
              break_o     <= (shift == 8'h00);
`endif
            end
          end
        end

        WAIT_IDLE: begin
          if (!rx_sync) begin
            idle_cnt <= '0;
          end else if (tick) begin
            if (idle_cnt == 4'd15) begin
              state   <= IDLE;
              busy_o  <= 1'b0;
`ifdef SERIAL_RX_BREAK_DET_EN
              break_o <= 1'b0;
`endif
            end else begin
              idle_cnt <= idle_cnt + 4'd1;
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: drives UART frames at nominal and skewed rates and
// scores delivered bytes, pulses and timing against a queue of expected bytes.
`timescale 1ns/1ps

module tb_serial_rx;

  localparam real CLK_NS  = 20.0;
  localparam real BIT_NS  = 1.0e9 / 115200.0;
  localparam int  LAT_CYC = 27 * 7 + 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;
`ifdef SERIAL_RX_BREAK_DET_EN
  logic       break_o;
`endif

  serial_rx dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
`ifdef SERIAL_RX_BREAK_DET_EN
    .busy_o      (busy_o),
    .break_o     (break_o)
`else
    .busy_o      (busy_o)
`endif
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: bytes that must appear on data_o, in order, each with a latest arrival time.
  logic [7:0] exp_q[$];
  realtime    dl_q[$];

  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   vcyc   = 0;
  bit   busy_seen = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_hs    = 1'b0;
  logic prev_fe    = 1'b0;
  logic prev_ov    = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input real bit_ns, input bit deliver);
    rx_i = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      #(bit_ns);
    end
    rx_i = 1'b1;
    if (deliver) begin
      exp_q.push_back(d);
      dl_q.push_back($realtime + bit_ns / 2.0 + LAT_CYC * CLK_NS);
    end
    #(bit_ns);
  endtask

  // Compare process: every new load of data_o must be the next expected byte, on time,
  // and data_o must not move while an unconsumed byte is held.
  always @(negedge clk) begin
    logic    new_load;
    realtime dl;
    if (rst_i) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_fe    = 1'b0;
      prev_ov    = 1'b0;
    end else begin
      new_load = valid_o && (!prev_valid || prev_hs);
      if (new_load) begin
        check("load_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("load_data", data_o, exp_q.pop_front());
          dl = dl_q.pop_front();
          check("load_latency", ($realtime <= dl), 1);
        end
      end else if (valid_o && prev_valid) begin
        check("held_stable", data_o, prev_data);
      end
      if (frame_err_o) begin
        fe_cnt++;
        check("fe_one_cycle", prev_fe, 0);
      end
      if (overrun_o) begin
        ov_cnt++;
        check("ov_one_cycle", prev_ov, 0);
      end
      if (valid_o) vcyc++;
      if (busy_o) busy_seen = 1'b1;
      prev_valid = valid_o;
      prev_hs    = valid_o && ready_i;
      prev_fe    = frame_err_o;
      prev_ov    = overrun_o;
      prev_data  = data_o;
    end
  end

  initial begin
    #(5.0e6);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, o0;

    rst_i   = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", data_o, 8'h00);
    check("rst_valid", valid_o, 0);
    check("rst_fe", frame_err_o, 0);
    check("rst_ov", overrun_o, 0);
    check("rst_busy", busy_o, 0);
`ifdef SERIAL_RX_BREAK_DET_EN
    check("rst_break", break_o, 0);
`endif
    @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_busy", busy_o, 0);

    // Single byte, consumer always ready.
    v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h55, BIT_NS, 1'b1);
    #(BIT_NS);
    check("b55_valid_cycles", vcyc - v0, 1);
    check("b55_fe", fe_cnt - f0, 0);
    check("b55_ov", ov_cnt - o0, 0);
    check("b55_data", data_o, 8'h55);

    // Back-to-back frames with the consumer stalled: second byte is dropped.
    @(posedge clk);
    #1 ready_i = 1'b0;
    o0 = ov_cnt;
    send_frame(8'hAA, BIT_NS, 1'b1);
    send_frame(8'h31, BIT_NS, 1'b0);
    check("ovr_count", ov_cnt - o0, 1);
    check("ovr_held_data", data_o, 8'hAA);
    check("ovr_held_valid", valid_o, 1);
    @(posedge clk);
    #1 ready_i = 1'b1;
    @(negedge clk);
    check("ovr_valid_before_hs", valid_o, 1);
    @(negedge clk);
    check("ovr_valid_after_hs", valid_o, 0);
    #(BIT_NS);

    // Line held low for one full frame: framing error, no byte.
    v0 = vcyc; f0 = fe_cnt;
    rx_i = 1'b0;
    #(86800);
    rx_i = 1'b1;
`ifdef SERIAL_RX_BREAK_DET_EN
    check("brk_high", break_o, 1);
    #(2.0 * BIT_NS);
    check("brk_low", break_o, 0);
`else
    #(2.0 * BIT_NS);
`endif
    check("brk_fe", fe_cnt - f0, 1);
    check("brk_no_valid", vcyc - v0, 0);
    check("brk_busy", busy_o, 0);
    send_frame(8'h31, BIT_NS, 1'b1);
    #(BIT_NS);
    check("after_brk_data", data_o, 8'h31);

    // 200 ns glitch on an idle line: false start, silently abandoned.
    v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
    busy_seen = 1'b0;
    rx_i = 1'b0;
    #(200);
    rx_i = 1'b1;
    #(BIT_NS - 200.0);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_low", busy_o, 0);
    #(BIT_NS);
    check("glitch_no_valid", vcyc - v0, 0);
    check("glitch_no_fe", fe_cnt - f0, 0);
    check("glitch_no_ov", ov_cnt - o0, 0);

    // Reset in the middle of data bit 4 of 0x55.
    v0 = vcyc;
    rx_i = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx_i = (8'h55 >> i) & 8'h01;
      #(BIT_NS);
    end
    rx_i = 1'b1;
    #(BIT_NS / 2.0);
    rst_i = 1'b1;
    #(100);
    check("mid_rst_data", data_o, 8'h00);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    #(2.0 * BIT_NS);
    check("post_rst_no_valid", vcyc - v0, 0);
    check("post_rst_busy", busy_o, 0);
    send_frame(8'hAA, BIT_NS, 1'b1);
    #(BIT_NS);
    check("post_rst_data", data_o, 8'hAA);

    // Transmitter clock skew of +2% and -2%.
    send_frame(8'h55, BIT_NS * 1.02, 1'b1);
    send_frame(8'hAA, BIT_NS * 1.02, 1'b1);
    #(BIT_NS);
    check("skew_slow_data", data_o, 8'hAA);
    send_frame(8'h55, BIT_NS * 0.98, 1'b1);
    send_frame(8'hAA, BIT_NS * 0.98, 1'b1);
    #(BIT_NS);
    check("skew_fast_data", data_o, 8'hAA);

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
